// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU control path.
// Frame-step tick masks are indexed by the new step number.
package spu_pkg;

  typedef logic [3:0]  ubit4_t;
  typedef logic [8:0]  ubit9_t;
  typedef logic [10:0] ubit11_t;
  typedef logic [11:0] ubit12_t;
  typedef logic [12:0] ubit13_t;

  typedef struct packed {
    logic [2:0] period;
    logic       negate;
    logic [2:0] shift;
  } sweep_cfg_t;

  localparam logic [7:0] STEP_LEN_MASK   = 8'b01010101;
  localparam logic [7:0] STEP_SWEEP_MASK = 8'b01000100;
  localparam logic [7:0] STEP_ENV_MASK   = 8'b10000000;

  localparam int LEN_MAX_SQ   = 64;
  localparam int LEN_MAX_WAVE = 256;

  function automatic ubit12_t sweep_calc(
    input ubit11_t    shadow,
    input logic       negate,
    input logic [2:0] shift
  );
    ubit11_t delta;
    delta = shadow >> shift;
    if (negate)
      sweep_calc = {1'b0, shadow} - {1'b0, delta};
    else
      sweep_calc = {1'b0, shadow} + {1'b0, delta};
  endfunction

endpackage

// File: rtl/spu_env_unit.sv
// Volume envelope for one square/noise channel.
// Reads the live NRx2 config; clr holds it idle while sound is off.
module spu_env_unit
  import spu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       trig,
  input  logic       env_tick,
  input  logic [7:0] cfg,
  output ubit4_t     vol
);

  logic [2:0] timer;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vol   <= '0;
      timer <= '0;
    end else if (trig) begin
      vol   <= cfg[7:4];
      timer <= cfg[2:0];
    end else if (env_tick && cfg[2:0] != 3'd0) begin
      if (timer > 3'd1) begin
        timer <= timer - 3'd1;
      end else begin
        timer <= cfg[2:0];
        if (cfg[3] && vol != 4'hF)
          vol <= vol + 4'd1;
        else if (!cfg[3] && vol != 4'h0)
          vol <= vol - 4'd1;
      end
    end
  end

endmodule

// File: rtl/spu_frame_sequencer.sv
// SPU control half: 512 Hz frame sequencer, length counters,
// envelopes and the ch1 frequency sweep.
module spu_frame_sequencer
  import spu_pkg::*;
#(
  parameter int DIV_MAX = 8191
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sound_on,
  input  logic [3:0]  trig,
  input  logic [3:0]  len_en,
  input  logic [5:0]  len_init1,
  input  logic [5:0]  len_init2,
  input  logic [7:0]  len_init3,
  input  logic [5:0]  len_init4,
  input  logic [7:0]  env_cfg1,
  input  logic [7:0]  env_cfg2,
  input  logic [7:0]  env_cfg4,
  input  logic        s3_dac,
  input  logic [6:0]  sweep_cfg,
  input  logic [10:0] freq1_init,
  output logic [3:0]  ch_en,
  output logic [3:0]  vol1,
  output logic [3:0]  vol2,
  output logic [3:0]  vol4,
  output logic [10:0] freq1,
  output logic        len_tick,
  output logic        env_tick,
  output logic        sweep_tick
);

  localparam ubit13_t DIV_LAST = ubit13_t'(DIV_MAX);

  logic       clr;
  ubit13_t    div_q;
  logic [2:0] step_q;
  logic [2:0] step_nx;

  assign clr     = !sound_on;
  assign step_nx = step_q + 3'd1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_q      <= '0;
      step_q     <= '0;
      len_tick   <= 1'b0;
      env_tick   <= 1'b0;
      sweep_tick <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q      <= '0;
      step_q     <= step_nx;
      len_tick   <= STEP_LEN_MASK[step_nx];
      env_tick   <= STEP_ENV_MASK[step_nx];
      sweep_tick <= STEP_SWEEP_MASK[step_nx];
    end else begin
      div_q      <= div_q + 13'd1;
      len_tick   <= 1'b0;
      env_tick   <= 1'b0;
      sweep_tick <= 1'b0;
    end
  end

  sweep_cfg_t sw;
  assign sw = sweep_cfg_t'(sweep_cfg);

  logic [3:0] dac;
  assign dac = {
    env_cfg4[7:3] != 5'd0,
    s3_dac,
    env_cfg2[7:3] != 5'd0,
    env_cfg1[7:3] != 5'd0
  };

  ubit9_t len_ld [4];
  assign len_ld[0] = ubit9_t'(LEN_MAX_SQ)   - {3'b0, len_init1};
  assign len_ld[1] = ubit9_t'(LEN_MAX_SQ)   - {3'b0, len_init2};
  assign len_ld[2] = ubit9_t'(LEN_MAX_WAVE) - {1'b0, len_init3};
  assign len_ld[3] = ubit9_t'(LEN_MAX_SQ)   - {3'b0, len_init4};

  ubit9_t     len_q  [4];
  ubit9_t     len_d  [4];
  logic [3:0] en_d;
  ubit11_t    shadow_q, shadow_d;
  ubit11_t    freq_d;
  logic [3:0] stimer_q, stimer_d;
  logic       sactive_q, sactive_d;
  logic [3:0] s_reload;
  ubit12_t    s_init, s_tick;
  logic       ovf_init, ovf_tick;

  assign s_reload = (sw.period == 3'd0) ? 4'd8 : {1'b0, sw.period};
  assign s_init   = sweep_calc(freq1_init, sw.negate, sw.shift);
  assign s_tick   = sweep_calc(shadow_q, sw.negate, sw.shift);
  assign ovf_init = !sw.negate && s_init[11];
  assign ovf_tick = !sw.negate && s_tick[11];

  always_comb begin
    en_d      = ch_en;
    shadow_d  = shadow_q;
    freq_d    = freq1;
    stimer_d  = stimer_q;
    sactive_d = sactive_q;
    for (int i = 0; i < 4; i++) begin
      len_d[i] = len_q[i];
      if (trig[i]) begin
        len_d[i] = len_ld[i];
        en_d[i]  = dac[i];
      end else if (len_tick && len_en[i] && len_q[i] != 9'd0) begin
        len_d[i] = len_q[i] - 9'd1;
        if (len_q[i] == 9'd1)
          en_d[i] = 1'b0;
      end
    end
    // Sweep may additionally clear ch1 on top of any length result.
    if (trig[0]) begin
      shadow_d  = freq1_init;
      freq_d    = freq1_init;
      stimer_d  = s_reload;
      sactive_d = (sw.period != 3'd0) || (sw.shift != 3'd0);
      if (sw.shift != 3'd0 && ovf_init)
        en_d[0] = 1'b0;
    end else if (sweep_tick && sactive_q) begin
      if (stimer_q > 4'd1) begin
        stimer_d = stimer_q - 4'd1;
      end else begin
        stimer_d = s_reload;
        if (sw.period != 3'd0) begin
          if (ovf_tick) begin
            en_d[0] = 1'b0;
          end else if (sw.shift != 3'd0) begin
            shadow_d = s_tick[10:0];
            freq_d   = s_tick[10:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ch_en     <= '0;
      freq1     <= '0;
      shadow_q  <= '0;
      stimer_q  <= '0;
      sactive_q <= 1'b0;
      for (int i = 0; i < 4; i++)
        len_q[i] <= '0;
    end else begin
      ch_en     <= en_d;
      freq1     <= freq_d;
      shadow_q  <= shadow_d;
      stimer_q  <= stimer_d;
      sactive_q <= sactive_d;
      for (int i = 0; i < 4; i++)
        len_q[i] <= len_d[i];
    end
  end

  spu_env_unit u_env1 (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .trig     (trig[0]),
    .env_tick (env_tick),
    .cfg      (env_cfg1),
    .vol      (vol1)
  );

  spu_env_unit u_env2 (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .trig     (trig[1]),
    .env_tick (env_tick),
    .cfg      (env_cfg2),
    .vol      (vol2)
  );

  spu_env_unit u_env4 (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .trig     (trig[3]),
    .env_tick (env_tick),
    .cfg      (env_cfg4),
    .vol      (vol4)
  );

endmodule

// File: tb/tb_spu_frame_sequencer.sv
// Directed bench for spu_frame_sequencer with DIV_MAX=15.
// Expected values are queued at stimulus time and popped at output.
module tb_spu_frame_sequencer;

  localparam int DIVM = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        sound_on;
  logic [3:0]  trig;
  logic [3:0]  len_en;
  logic [5:0]  len_init1, len_init2, len_init4;
  logic [7:0]  len_init3;
  logic [7:0]  env_cfg1, env_cfg2, env_cfg4;
  logic        s3_dac;
  logic [6:0]  sweep_cfg;
  logic [10:0] freq1_init;
  logic [3:0]  ch_en, vol1, vol2, vol4;
  logic [10:0] freq1;
  logic        len_tick, env_tick, sweep_tick;

  spu_frame_sequencer #(.DIV_MAX(DIVM)) dut (
    .clk        (clk),
    .rst        (rst),
    .sound_on   (sound_on),
    .trig       (trig),
    .len_en     (len_en),
    .len_init1  (len_init1),
    .len_init2  (len_init2),
    .len_init3  (len_init3),
    .len_init4  (len_init4),
    .env_cfg1   (env_cfg1),
    .env_cfg2   (env_cfg2),
    .env_cfg4   (env_cfg4),
    .s3_dac     (s3_dac),
    .sweep_cfg  (sweep_cfg),
    .freq1_init (freq1_init),
    .ch_en      (ch_en),
    .vol1       (vol1),
    .vol2       (vol2),
    .vol4       (vol4),
    .freq1      (freq1),
    .len_tick   (len_tick),
    .env_tick   (env_tick),
    .sweep_tick (sweep_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_asrt = 0;
  int   n_fail = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_asrt++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0h required none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic tick_of(input int which);
    case (which)
      0:       tick_of = len_tick;
      1:       tick_of = sweep_tick;
      default: tick_of = env_tick;
    endcase
  endfunction

  task automatic wait_tick(input int which);
    int   n;
    logic hit;
    n = 0;
    @(negedge clk);
    hit = tick_of(which);
    while (!hit && n < 400) begin
      @(negedge clk);
      n++;
      hit = tick_of(which);
    end
    n_asrt++;
    assert (hit === 1'b1) else begin
      n_fail++;
      $error("FAIL tick_timeout_%0d: observed 0 required 1", which);
    end
  endtask

  task automatic pulse(input logic [3:0] t);
    trig = t;
    @(negedge clk);
    trig = 4'h0;
  endtask

  task automatic expect_idle(input string tag);
    expect_v({tag, "_ch_en"}, 32'h0);
    check({28'h0, ch_en});
    expect_v({tag, "_vol1"}, 32'h0);
    check({28'h0, vol1});
    expect_v({tag, "_vol2"}, 32'h0);
    check({28'h0, vol2});
    expect_v({tag, "_vol4"}, 32'h0);
    check({28'h0, vol4});
    expect_v({tag, "_freq1"}, 32'h0);
    check({21'h0, freq1});
    expect_v({tag, "_ticks"}, 32'h0);
    check({29'h0, len_tick, sweep_tick, env_tick});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst        = 1'b1;
    sound_on   = 1'b0;
    trig       = 4'h0;
    len_en     = 4'h0;
    len_init1  = 6'd0;
    len_init2  = 6'd0;
    len_init3  = 8'd0;
    len_init4  = 6'd0;
    env_cfg1   = 8'h00;
    env_cfg2   = 8'h00;
    env_cfg4   = 8'h00;
    s3_dac     = 1'b0;
    sweep_cfg  = 7'h00;
    freq1_init = 11'h000;
    repeat (3) @(negedge clk);
    expect_idle("reset");
    rst      = 1'b0;
    sound_on = 1'b1;

    // Length on ch2: counter 2 -> off on 2nd len_tick
    env_cfg2  = 8'hF0;
    len_init2 = 6'd62;
    len_en    = 4'b0010;
    pulse(4'b0010);
    expect_v("len_trig_en", 32'h1);
    check({31'h0, ch_en[1]});
    expect_v("len_trig_vol2", 32'hF);
    check({28'h0, vol2});
    expect_v("len_tick1_en", 32'h1);
    expect_v("len_tick2_en", 32'h0);
    wait_tick(0);
    @(negedge clk);
    check({31'h0, ch_en[1]});
    wait_tick(0);
    @(negedge clk);
    check({31'h0, ch_en[1]});
    len_en = 4'h0;

    // Envelope decreasing to 0 then held
    env_cfg1 = 8'h21;
    pulse(4'b0001);
    expect_v("env_dn_trig", 32'h2);
    check({28'h0, vol1});
    expect_v("env_dn_ch_en", 32'h1);
    check({31'h0, ch_en[0]});
    expect_v("env_dn_1", 32'h1);
    expect_v("env_dn_2", 32'h0);
    expect_v("env_dn_3", 32'h0);
    repeat (3) begin
      wait_tick(2);
      @(negedge clk);
      check({28'h0, vol1});
    end

    // Envelope increasing, saturates at 15
    env_cfg1 = 8'hE9;
    pulse(4'b0001);
    expect_v("env_up_trig", 32'hE);
    check({28'h0, vol1});
    expect_v("env_up_1", 32'hF);
    expect_v("env_up_2", 32'hF);
    repeat (2) begin
      wait_tick(2);
      @(negedge clk);
      check({28'h0, vol1});
    end

    // Sweep overflow at trigger
    env_cfg1   = 8'hF0;
    sweep_cfg  = 7'h11;
    freq1_init = 11'h700;
    pulse(4'b0001);
    expect_v("sweep_ovf_en", 32'h0);
    check({31'h0, ch_en[0]});
    expect_v("sweep_ovf_freq", 32'h700);
    check({21'h0, freq1});

    // Sweep additive updates
    freq1_init = 11'h100;
    pulse(4'b0001);
    expect_v("sweep_add_en", 32'h1);
    check({31'h0, ch_en[0]});
    expect_v("sweep_add_f0", 32'h100);
    check({21'h0, freq1});
    expect_v("sweep_add_f1", 32'h180);
    expect_v("sweep_add_f2", 32'h240);
    repeat (2) begin
      wait_tick(1);
      @(negedge clk);
      check({21'h0, freq1});
    end

    // Sweep negate
    sweep_cfg = 7'h19;
    pulse(4'b0001);
    expect_v("sweep_neg_f1", 32'h080);
    wait_tick(1);
    @(negedge clk);
    check({21'h0, freq1});
    sweep_cfg = 7'h00;

    // DAC gating on ch4 and ch3, plus ch3 length boundary
    env_cfg4 = 8'h07;
    pulse(4'b1000);
    expect_v("dac4_off", 32'h0);
    check({31'h0, ch_en[3]});
    env_cfg4 = 8'h08;
    pulse(4'b1000);
    expect_v("dac4_on", 32'h1);
    check({31'h0, ch_en[3]});
    s3_dac = 1'b0;
    pulse(4'b0100);
    expect_v("dac3_off", 32'h0);
    check({31'h0, ch_en[2]});
    s3_dac    = 1'b1;
    len_init3 = 8'd255;
    len_en    = 4'b0100;
    pulse(4'b0100);
    expect_v("dac3_on", 32'h1);
    check({31'h0, ch_en[2]});
    expect_v("len3_expire", 32'h0);
    wait_tick(0);
    @(negedge clk);
    check({31'h0, ch_en[2]});
    len_en = 4'h0;

    // Power drop mid step 5
    freq1_init = 11'h123;
    pulse(4'b0001);
    expect_v("pre_drop_freq", 32'h123);
    check({21'h0, freq1});
    wait_tick(2);
    repeat (3) wait_tick(0);
    repeat (20) @(negedge clk);
    expect_v("pre_drop_ch_en", 32'h9);
    check({28'h0, ch_en});
    expect_v("pre_drop_vol1", 32'hF);
    check({28'h0, vol1});
    sound_on = 1'b0;
    @(negedge clk);
    expect_idle("drop");
    pulse(4'hF);
    expect_v("off_trig_ignored", 32'h0);
    check({28'h0, ch_en});

    // Re-enable: first tick arrives at the wrap into step 2
    env_cfg2  = 8'hF0;
    len_init2 = 6'd62;
    len_en    = 4'b0010;
    sound_on  = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(len_tick || sweep_tick || env_tick) && cnt < 400);
    expect_v("reen_latency", 32'(2 * (DIVM + 1)));
    check(32'(cnt));
    expect_v("reen_ticks", 32'h6);
    check({29'h0, len_tick, sweep_tick, env_tick});

    // Trigger coincident with len_tick: load wins
    trig = 4'b0010;
    @(negedge clk);
    trig = 4'h0;
    expect_v("coinc_en", 32'h1);
    check({31'h0, ch_en[1]});
    expect_v("coinc_tick1", 32'h1);
    expect_v("coinc_tick2", 32'h0);
    wait_tick(0);
    @(negedge clk);
    check({31'h0, ch_en[1]});
    wait_tick(0);
    @(negedge clk);
    check({31'h0, ch_en[1]});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
